// File: rtl/clock_time_setter.sv
// Front-panel time/date setter: debounced mode/inc/dec keys walk an edit FSM over shadow
// hour/minute/day/month registers, with auto-repeat, edit timeout, blink and a one-cycle load strobe.
module clock_time_setter #(
  parameter int DB_SAMPLES   = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int TIMEOUT      = 1024,
  parameter int BLINK_HALF   = 8
) (
  input  logic       reset,
  input  logic       clock,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [4:0] cur_day,
  input  logic [3:0] cur_month,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [4:0] set_day,
  output logic [3:0] set_month,
  output logic       load,
  output logic       run_enable,
  output logic [2:0] edit_field,
  output logic       blink
);

  localparam int DBW = $clog2(DB_SAMPLES + 1);
  localparam int RW  = $clog2(REPEAT_DELAY + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_HOUR   = 3'd1,
    S_MINUTE = 3'd2,
    S_DAY    = 3'd3,
    S_MONTH  = 3'd4,
    S_COMMIT = 3'd5
  } state_t;

  state_t state;

  // key index: 0 = mode, 1 = inc, 2 = dec
  logic [2:0]     raw;
  logic [2:0]     lvl;
  logic [2:0]     lvl_d;
  logic [DBW-1:0] db_cnt [3];
  logic [RW-1:0]  rep_cnt [1:2];
  logic [2:1]     rep_hit;
  logic [2:1]     rep_q;
  logic [2:0]     evt;
  logic [TW-1:0]  to_cnt;
  logic [BW-1:0]  blink_cnt;

  assign raw = {key_dec, key_inc, key_mode};

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                           input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
      lvl   <= '0;
      lvl_d <= '0;
    end else begin
      lvl_d <= lvl;
      if (tick) begin
        for (int k = 0; k < 3; k++) begin
          if (raw[k] == lvl[k]) begin
            db_cnt[k] <= '0;
          end else if (db_cnt[k] == DBW'(DB_SAMPLES - 1)) begin
            lvl[k]    <= raw[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rep_hit = '0;
    for (int k = 1; k <= 2; k++)
      rep_hit[k] = tick && lvl[k] && (rep_cnt[k] == RW'(REPEAT_DELAY - 1));
  end

  // Repeat hits are delayed one cycle so they line up with press pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= 2; k++) rep_cnt[k] <= '0;
      rep_q <= '0;
      evt   <= '0;
    end else begin
      for (int k = 1; k <= 2; k++) begin
        if (!lvl[k])         rep_cnt[k] <= '0;
        else if (rep_hit[k]) rep_cnt[k] <= RW'(REPEAT_DELAY - REPEAT_RATE);
        else if (tick)       rep_cnt[k] <= rep_cnt[k] + 1'b1;
      end
      rep_q  <= rep_hit;
      evt[0] <= lvl[0] & ~lvl_d[0];
      evt[1] <= (lvl[1] & ~lvl_d[1]) | rep_q[1];
      evt[2] <= (lvl[2] & ~lvl_d[2]) | rep_q[2];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_RUN;
      run_enable <= 1'b1;
      load       <= 1'b0;
      blink      <= 1'b0;
      edit_field <= 3'd0;
      set_hour   <= '0;
      set_minute <= '0;
      set_day    <= '0;
      set_month  <= '0;
      to_cnt     <= '0;
      blink_cnt  <= '0;
    end else begin
      case (state)
        S_RUN: begin
          run_enable <= 1'b1;
          load       <= 1'b0;
          blink      <= 1'b0;
          edit_field <= 3'd0;
          to_cnt     <= '0;
          blink_cnt  <= '0;
          if (evt[0]) begin
            set_hour   <= cur_hour;
            set_minute <= cur_minute;
            set_day    <= cur_day;
            set_month  <= cur_month;
            run_enable <= 1'b0;
            edit_field <= 3'd1;
            state      <= S_HOUR;
          end
        end
        S_COMMIT: begin
          load       <= 1'b0;
          run_enable <= 1'b1;
          edit_field <= 3'd0;
          state      <= S_RUN;
        end
        default: begin
          if (tick) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
          if (evt[0]) begin
            to_cnt <= '0;
            if (state == S_MONTH) begin
              state      <= S_COMMIT;
              load       <= 1'b1;
              blink      <= 1'b0;
              blink_cnt  <= '0;
              edit_field <= 3'd0;
            end else begin
              state      <= state_t'(state + 3'd1);
              edit_field <= edit_field + 3'd1;
            end
          end else if (|evt) begin
            to_cnt <= '0;
            if (evt[1] ^ evt[2]) begin
              case (state)
                S_HOUR:   set_hour   <= 5'(wrap_step({1'b0, set_hour}, 6'd23, evt[1]));
                S_MINUTE: set_minute <= wrap_step(set_minute, 6'd59, evt[1]);
                S_DAY:    set_day    <= 5'(wrap_step({1'b0, set_day}, 6'd30, evt[1]));
                default:  set_month  <= 4'(wrap_step({2'b0, set_month}, 6'd11, evt[1]));
              endcase
            end
          end else if (tick) begin
            if (to_cnt == TW'(TIMEOUT - 1)) begin
              // abandon the edit: shadow values stay, no load
              state      <= S_RUN;
              run_enable <= 1'b1;
              edit_field <= 3'd0;
              blink      <= 1'b0;
              blink_cnt  <= '0;
              to_cnt     <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed + randomized key sequences for clock_time_setter, checked tick-by-tick against a behavioural model.
module tb_clock_time_setter;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;
  localparam int TO = 1024;
  localparam int BH = 8;

  logic       reset = 1'b0;
  logic       clock = 1'b0;
  logic       tick = 1'b0;
  logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_minute = '0;
  logic [4:0] cur_day = '0;
  logic [3:0] cur_month = '0;
  logic [4:0] set_hour;
  logic [5:0] set_minute;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic       load, run_enable, blink;
  logic [2:0] edit_field;

  clock_time_setter dut (
    .reset(reset), .clock(clock), .tick(tick),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_day(cur_day), .cur_month(cur_month),
    .set_hour(set_hour), .set_minute(set_minute), .set_day(set_day), .set_month(set_month),
    .load(load), .run_enable(run_enable), .edit_field(edit_field), .blink(blink)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;

  // load monitor: every cycle with load high is counted and its snapshot kept
  int   load_seen = 0;
  int   ld_h, ld_m, ld_d, ld_mo;
  logic ld_run;
  always @(negedge clock) begin
    if (load === 1'b1) begin
      load_seen++;
      ld_h = set_hour; ld_m = set_minute; ld_d = set_day; ld_mo = set_month;
      ld_run = run_enable;
    end
  end

  // behavioural model: state 0=RUN 1..4=field being edited
  int          m_state, m_h, m_m, m_d, m_mo;
  bit [DB-1:0] hist [3];
  int          m_lvl [3];
  int          held [3];
  int          idle, bticks, commits, last_commits;
  int          e_h, e_m, e_d, e_mo;

  function automatic int wrap(input int v, input int modulus, input bit up);
    return up ? (v + 1) % modulus : (v + modulus - 1) % modulus;
  endfunction

  task automatic model_reset();
    m_state = 0; m_h = 0; m_m = 0; m_d = 0; m_mo = 0;
    for (int k = 0; k < 3; k++) begin hist[k] = '0; m_lvl[k] = 0; held[k] = 0; end
    idle = 0; bticks = 0;
  endtask

  task automatic model_tick(input bit m, input bit i, input bit d);
    bit r [3];
    bit ev [3];
    r[0] = m; r[1] = i; r[2] = d;
    for (int k = 0; k < 3; k++) begin
      ev[k] = 0;
      if (m_lvl[k] == 1) begin
        held[k]++;
        if (k > 0 && held[k] >= RD && (held[k] - RD) % RR == 0) ev[k] = 1;
      end
      hist[k] = {hist[k][DB-2:0], r[k]};
      if (hist[k] == {DB{1'b1}} && m_lvl[k] == 0) begin
        m_lvl[k] = 1; held[k] = 0; ev[k] = 1;
      end else if (hist[k] == '0 && m_lvl[k] == 1) begin
        m_lvl[k] = 0; held[k] = 0;
      end
    end
    if (m_state != 0) begin
      bticks++;
      idle++;
      if (idle == TO) m_state = 0;
    end
    if (ev[0] || ev[1] || ev[2]) idle = 0;
    if (m_state == 0) begin
      if (ev[0]) begin
        m_h = cur_hour; m_m = cur_minute; m_d = cur_day; m_mo = cur_month;
        m_state = 1; bticks = 0;
      end
    end else if (ev[0]) begin
      if (m_state == 4) begin
        commits++;
        e_h = m_h; e_m = m_m; e_d = m_d; e_mo = m_mo;
        m_state = 0;
      end else begin
        m_state++;
      end
    end else if (ev[1] != ev[2]) begin
      case (m_state)
        1: m_h  = wrap(m_h, 24, ev[1]);
        2: m_m  = wrap(m_m, 60, ev[1]);
        3: m_d  = wrap(m_d, 31, ev[1]);
        default: m_mo = wrap(m_mo, 12, ev[1]);
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/edit_field"}, 32'(edit_field), m_state);
    check({tag, "/run_enable"}, 32'(run_enable), (m_state == 0) ? 1 : 0);
    check({tag, "/set_hour"}, 32'(set_hour), m_h);
    check({tag, "/set_minute"}, 32'(set_minute), m_m);
    check({tag, "/set_day"}, 32'(set_day), m_d);
    check({tag, "/set_month"}, 32'(set_month), m_mo);
    check({tag, "/blink"}, 32'(blink), (m_state != 0) ? (bticks / BH) % 2 : 0);
    check({tag, "/load_count"}, load_seen, commits);
    if (commits != last_commits && load_seen == commits) begin
      check({tag, "/load_hour"}, ld_h, e_h);
      check({tag, "/load_minute"}, ld_m, e_m);
      check({tag, "/load_day"}, ld_d, e_d);
      check({tag, "/load_month"}, ld_mo, e_mo);
      check({tag, "/load_run_enable"}, 32'(ld_run), 0);
    end
    last_commits = commits;
  endtask

  // one prescaler tick with the given raw key levels, then settle and compare
  task automatic do_tick(input string tag, input bit m, input bit i, input bit d);
    key_mode = m; key_inc = i; key_dec = d;
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    repeat (3) @(negedge clock);
    model_tick(m, i, d);
    compare_all(tag);
  endtask

  task automatic do_press(input string tag, input bit m, input bit i, input bit d, input int hold);
    for (int t = 0; t < hold; t++) do_tick(tag, m, i, d);
    for (int t = 0; t < DB + 1; t++) do_tick(tag, 0, 0, 0);
  endtask

  task automatic set_cur(input int h, input int mi, input int d, input int mo);
    cur_hour = 5'(h); cur_minute = 6'(mi); cur_day = 5'(d); cur_month = 4'(mo);
  endtask

  initial begin
    commits = 0; last_commits = 0;
    model_reset();
    repeat (3) @(negedge clock);
    compare_all("reset");
    check("reset/load", 32'(load), 0);
    reset = 1'b1;
    @(negedge clock);

    set_cur(13, 45, 7, 2);
    do_press("enter", 1, 0, 0, DB);
    do_tick("glitch", 0, 1, 0); do_tick("glitch", 0, 1, 0); do_tick("glitch", 0, 1, 0);
    do_press("glitch", 0, 0, 0, 2);
    do_press("mode_inc", 1, 1, 0, DB);
    do_press("inc_dec", 0, 1, 1, DB);
    do_press("to_day", 1, 0, 0, DB);
    do_press("to_month", 1, 0, 0, DB);
    do_press("commit", 1, 0, 0, DB);

    set_cur(23, 0, 30, 11);
    do_press("wrap", 1, 0, 0, DB);
    do_press("hour_inc", 0, 1, 0, DB);
    do_press("hour_dec", 0, 0, 1, DB);
    do_press("wrap", 1, 0, 0, DB);
    do_press("min_dec", 0, 0, 1, DB);
    do_press("min_inc", 0, 1, 0, DB);
    do_press("wrap", 1, 0, 0, DB);
    do_press("day_inc", 0, 1, 0, DB);
    do_press("day_dec", 0, 0, 1, DB);
    do_press("wrap", 1, 0, 0, DB);
    do_press("month_inc", 0, 1, 0, DB);
    do_press("commit2", 1, 0, 0, DB);

    set_cur(8, 10, 3, 5);
    do_press("rpt", 1, 0, 0, DB);
    do_press("rpt", 1, 0, 0, DB);
    do_press("repeat", 0, 1, 0, DB + RD + 2 * RR);
    do_press("repeat_dec", 0, 0, 1, DB + RD + $urandom_range(0, 12));

    do_press("to", 1, 0, 0, DB);
    for (int t = 0; t < TO + 4; t++) do_tick("timeout", 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int act;
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 30),
              $urandom_range(0, 11));
      act = $urandom_range(0, 7);
      case (act)
        0: do_press("rnd_mode", 1, 0, 0, DB + $urandom_range(0, 3));
        1: do_press("rnd_inc", 0, 1, 0, DB + $urandom_range(0, 3));
        2: do_press("rnd_dec", 0, 0, 1, DB + $urandom_range(0, 3));
        3: do_press("rnd_incdec", 0, 1, 1, DB + $urandom_range(0, 3));
        4: do_press("rnd_modeinc", 1, 1, 0, DB + $urandom_range(0, 3));
        5: do_press("rnd_modedec", 1, 0, 1, DB + $urandom_range(0, 3));
        6: do_press("rnd_holdinc", 0, 1, 0, DB + $urandom_range(0, 30));
        default: do_press("rnd_holddec", 0, 0, 1, DB + $urandom_range(0, 30));
      endcase
    end

    set_cur(5, 6, 7, 8);
    do_press("midreset", 1, 0, 0, DB);
    do_press("midreset", 0, 1, 0, DB);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("midreset");
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    compare_all("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
